mux_sel_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 4-bit mux cell between four requesters.
- Drives the mux `sel` input and a one-hot grant back to the requesters.
- Enforces a bounded hold time per grant so one requester cannot starve the others.
- Tracks the cell's power state: all grants are withdrawn while the mux supply is off, and arbitration restarts cleanly when it returns.

---
 rtl/mux_arb_pkg.sv | 34 +++
 rtl/rr_picker.sv | 19 +
 rtl/mux_sel_arbiter.sv | 115 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function for power-aware shared-cell arbiters.
package mux_arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      PWR_OFF = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } pick_t;

   // Rotate so that (ptr+1) lands on bit 0, take the lowest set bit, then undo the rotation.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      pick_t              p;
      dbl = {req, req} >> ({1'b0, ptr} + 3'd1);
      rot = dbl[N_REQ-1:0];
      p   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            p.valid = 1'b1;
            p.idx   = ptr + 2'(k) + 2'd1;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping 3 -> 0.
module rr_picker
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [1:0]       ptr_i,
   output logic             valid_o,
   output logic [1:0]       idx_o
);

   pick_t pick;

   always_comb begin
      pick    = rr_pick(req_i, ptr_i);
      valid_o = pick.valid;
      idx_o   = pick.idx;
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux cell with bounded hold time and supply tracking.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwr_on,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       sel,
   output logic             out_valid,
   output logic             busy,
   output arb_state_t       dbg_state_o,
   output logic [1:0]       dbg_rr_ptr_o,
   output logic [CNT_W-1:0] dbg_hold_cnt_o
);

   arb_state_t       state_q;
   logic [N_REQ-1:0] grant_q;
   logic [1:0]       sel_q;
   logic [1:0]       rr_ptr_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             pick_valid;
   logic [1:0]       pick_idx;
   logic             owner_req;
   logic             others_req;
   logic             hold_expired;
   logic             release_grant;

   // rr_ptr always equals the current owner, so a re-arbitration puts the owner last.
   rr_picker u_picker (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign owner_req     = |(req & grant_q);
   assign others_req    = |(req & ~grant_q);
   assign hold_expired  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) && others_req;
   assign release_grant = !owner_req || hold_expired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         sel_q       <= 2'd0;
         rr_ptr_q    <= 2'd3;
         hold_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (!pwr_on) begin
         // Supply loss overrides everything; sel and rr_ptr are deliberately kept.
         state_q     <= PWR_OFF;
         grant_q     <= '0;
         hold_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               out_valid_q <= 1'b0;
               if (pick_valid) begin
                  state_q    <= GRANT;
                  grant_q    <= N_REQ'(1) << pick_idx;
                  sel_q      <= pick_idx;
                  rr_ptr_q   <= pick_idx;
                  hold_cnt_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            GRANT: begin
               out_valid_q <= owner_req;
               if (release_grant) begin
                  hold_cnt_q <= '0;
                  if (pick_valid) begin
                     grant_q  <= N_REQ'(1) << pick_idx;
                     sel_q    <= pick_idx;
                     rr_ptr_q <= pick_idx;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                  end
               end else if (others_req && (hold_cnt_q < CNT_W'(MAX_HOLD))) begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            PWR_OFF: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant          = grant_q;
   assign sel            = sel_q;
   assign out_valid      = out_valid_q;
   assign busy           = busy_q;
   assign dbg_state_o    = state_q;
   assign dbg_rr_ptr_o   = rr_ptr_q;
   assign dbg_hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (MAX_HOLD=4) with a randomized invariant/fairness run.
module tb_mux_sel_arbiter;
   import mux_arb_pkg::*;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 8;

   logic             clk;
   logic             rst;
   logic             pwr_on;
   logic [3:0]       req;
   logic [3:0]       grant;
   logic [1:0]       sel;
   logic             out_valid;
   logic             busy;
   arb_state_t       dbg_state;
   logic [1:0]       dbg_rr_ptr;
   logic [CNT_W-1:0] dbg_hold_cnt;

   int tests = 0;
   int fails = 0;

   mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .pwr_on         (pwr_on),
      .req            (req),
      .grant          (grant),
      .sel            (sel),
      .out_valid      (out_valid),
      .busy           (busy),
      .dbg_state_o    (dbg_state),
      .dbg_rr_ptr_o   (dbg_rr_ptr),
      .dbg_hold_cnt_o (dbg_hold_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] exp_owner;
   logic [3:0] onehot;
   int         wait_cnt [4];
   logic       pwr_prev;

   initial begin
      rst    = 1'b1;
      pwr_on = 1'b1;
      req    = 4'b0000;
      #12;
      rst = 1'b0;

      check("rst_grant", 32'(grant), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'h3);
      check("rst_hold_cnt", 32'(dbg_hold_cnt), 32'h0);

      // Single requester: grant one cycle after req, out_valid one cycle after grant.
      req = 4'b0001;
      tick();
      check("t1_grant", 32'(grant), 32'h1);
      check("t1_sel", 32'(sel), 32'h0);
      check("t1_busy", 32'(busy), 32'h1);
      check("t1_ov_early", 32'(out_valid), 32'h0);
      tick();
      check("t1_ov", 32'(out_valid), 32'h1);
      check("t1_grant_kept", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      check("t1_drop_grant", 32'(grant), 32'h0);
      check("t1_drop_busy", 32'(busy), 32'h0);
      check("t1_drop_ov", 32'(out_valid), 32'h0);
      check("t1_drop_state", 32'(dbg_state), 32'(IDLE));

      // All four requesting: order 0,1,2,3,0, MAX_HOLD cycles each, no bubble.
      pulse_reset();
      req = 4'b1111;
      tick();
      for (int n = 0; n < 5; n++) begin
         exp_owner = 4'b0001 << (n % 4);
         for (int c = 0; c < MAX_HOLD; c++) begin
            check($sformatf("t2_grant_o%0d_c%0d", n, c), 32'(grant), 32'(exp_owner));
            check($sformatf("t2_sel_o%0d_c%0d", n, c), 32'(sel), 32'(n % 4));
            check($sformatf("t2_busy_o%0d_c%0d", n, c), 32'(busy), 32'h1);
            tick();
         end
      end

      // Lone requester keeps the grant indefinitely and never counts.
      pulse_reset();
      req = 4'b0100;
      tick();
      for (int c = 0; c < 50; c++) begin
         check($sformatf("t3_grant_c%0d", c), 32'(grant), 32'h4);
         check($sformatf("t3_hold_c%0d", c), 32'(dbg_hold_cnt), 32'h0);
         tick();
      end

      // Power drop while requester 2 owns with 1 also pending.
      req = 4'b0110;
      tick();
      check("t4_owner2", 32'(grant), 32'h4);
      check("t4_ov_before", 32'(out_valid), 32'h1);
      pwr_on = 1'b0;
      tick();
      check("t4_off_grant", 32'(grant), 32'h0);
      check("t4_off_ov", 32'(out_valid), 32'h0);
      check("t4_off_sel", 32'(sel), 32'h2);
      check("t4_off_busy", 32'(busy), 32'h0);
      check("t4_off_state", 32'(dbg_state), 32'(PWR_OFF));
      tick();
      check("t4_off_ignore_req", 32'(grant), 32'h0);
      pwr_on = 1'b1;
      tick();
      check("t4_on_state", 32'(dbg_state), 32'(IDLE));
      check("t4_on_grant", 32'(grant), 32'h0);
      tick();
      check("t4_regrant", 32'(grant), 32'h2);
      check("t4_regrant_sel", 32'(sel), 32'h1);

      // Asynchronous reset between edges.
      pulse_reset();
      req = 4'b0100;
      tick();
      check("t5_pre_grant", 32'(grant), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_grant", 32'(grant), 32'h0);
      check("t5_async_sel", 32'(sel), 32'h0);
      check("t5_async_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      req = 4'b1000;
      tick();
      check("t5_after_grant", 32'(grant), 32'h8);
      check("t5_after_sel", 32'(sel), 32'h3);

      // Random requests and supply toggles with invariant and fairness checks.
      pulse_reset();
      req      = 4'b0000;
      pwr_on   = 1'b1;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         end
         if (pwr_on && $urandom_range(0, 63) == 0) pwr_on = 1'b0;
         else if (!pwr_on && $urandom_range(0, 3) == 0) pwr_on = 1'b1;
         pwr_prev = pwr_on;
         tick();
         onehot = grant & (grant - 4'd1);
         check("rnd_onehot", 32'(onehot), 32'h0);
         check("rnd_sel", 32'((grant == 4'b0000) ? 4'b0000 : (4'b0001 << sel)), 32'(grant));
         check("rnd_busy", 32'(busy), 32'(grant != 4'b0000));
         if (!pwr_prev) check("rnd_pwr_off", 32'(grant), 32'h0);
         for (int i = 0; i < 4; i++) begin
            if (!pwr_prev || !req[i] || grant[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            check($sformatf("rnd_fair_%0d", i), 32'(wait_cnt[i] > 3 * MAX_HOLD + 3), 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
